// File: rtl/parking_pkg.sv
// Shared types for the parking task scheduler: task kinds, scheduler states
// and the queued request entry.
package parking_pkg;

  localparam int PLATE_W = 16;
  localparam int FLOOR_W = 3;

  typedef enum logic [1:0] {
    TASK_NONE,
    TASK_IN,
    TASK_OUT,
    TASK_LEAK
  } task_e;

  typedef enum logic {
    IDLE,
    BUSY
  } sched_state_e;

  typedef struct packed {
    task_e              kind;
    logic [PLATE_W-1:0] plate;
  } sched_entry_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous request FIFO; a push into a full queue is taken when a pop
// happens on the same edge. SCHED_DUP_FILTER_EN adds a queued-entry matcher.
module sched_fifo
  import parking_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  sched_entry_t             wdata_i,
  output sched_entry_t             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef SCHED_DUP_FILTER_EN
  ,
  input  sched_entry_t             query_i,
  output logic                     match_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sched_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

`ifdef SCHED_DUP_FILTER_EN
  // An entry is live when its distance from the read pointer is below count.
  logic [AW-1:0] off;
  always_comb begin
    match_o = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_q;
      if ({1'b0, off} < cnt_q && mem_q[i] == query_i) match_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/parking_task_scheduler.sv
// Queues in/out requests, captures leak events and issues one task at a time.
// Optional SCHED_DUP_FILTER_EN rejects requests duplicating a queued/current task.
module parking_task_scheduler
  import parking_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PLATE_W = parking_pkg::PLATE_W,
  parameter int FLOOR_W = parking_pkg::FLOOR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PLATE_W-1:0]     license_plate,
  input  logic                   in_mode,
  input  logic                   out_mode,
  input  logic                   leakage,
  input  logic [FLOOR_W-1:0]     leakage_floor,
  input  logic                   task_done,
  output logic                   todo_exists,
  output logic                   todo_in,
  output logic                   todo_out,
  output logic                   todo_leak_move,
  output logic [PLATE_W-1:0]     todo_license_plate,
  output logic [FLOOR_W-1:0]     todo_floor,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   queue_full,
  output logic                   req_dropped
);

  sched_state_e       state_q, state_d;
  task_e              task_q, task_d;
  logic [PLATE_W-1:0] plate_q, plate_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic [FLOOR_W-1:0] lfloor_prev_q;
  logic [FLOOR_W-1:0] leak_floor_q, leak_floor_d;
  logic               leak_prev_q;
  logic               leak_pend_q, leak_pend_d;
  logic               drop_q, drop_d;

  sched_entry_t head, wdata;
  logic full, empty, push, pop, is_req, dup;
  logic leak_evt, leak_go, load_leak;

  assign is_req      = in_mode ^ out_mode;
  assign wdata.kind  = in_mode ? TASK_IN : TASK_OUT;
  assign wdata.plate = license_plate;

`ifdef SCHED_DUP_FILTER_EN
  logic q_match;
  assign dup = q_match ||
               (task_q == wdata.kind && plate_q == license_plate);
`else
  assign dup = 1'b0;
`endif

  assign push   = is_req && (|license_plate) && !dup && (!full || pop);
  assign drop_d = (in_mode && out_mode) || (is_req && !push);

  assign leak_evt  = leakage && (|leakage_floor) &&
                     (!leak_prev_q || leakage_floor != lfloor_prev_q);
  assign leak_go   = leak_pend_q && leakage;
  assign load_leak = (state_q == IDLE) && leak_go;
  assign pop       = (state_q == IDLE) && !leak_go && !empty;

  sched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (queue_count)
`ifdef SCHED_DUP_FILTER_EN
    ,
    .query_i (wdata),
    .match_o (q_match)
`endif
  );

  always_comb begin
    leak_pend_d  = leak_pend_q;
    leak_floor_d = leak_floor_q;
    if (!leakage) begin
      leak_pend_d = 1'b0;
    end else if (leak_evt) begin
      leak_pend_d  = 1'b1;
      leak_floor_d = leakage_floor;
    end else if (load_leak) begin
      leak_pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    task_d  = task_q;
    plate_d = plate_q;
    floor_d = floor_q;
    unique case (state_q)
      IDLE: begin
        if (leak_go) begin
          state_d = BUSY;
          task_d  = TASK_LEAK;
          plate_d = '0;
          floor_d = leak_floor_q;
        end else if (!empty) begin
          state_d = BUSY;
          task_d  = head.kind;
          plate_d = head.plate;
          floor_d = '0;
        end
      end
      BUSY: begin
        if (task_done) begin
          state_d = IDLE;
          task_d  = TASK_NONE;
          plate_d = '0;
          floor_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      task_q        <= TASK_NONE;
      plate_q       <= '0;
      floor_q       <= '0;
      leak_prev_q   <= 1'b0;
      lfloor_prev_q <= '0;
      leak_pend_q   <= 1'b0;
      leak_floor_q  <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      task_q        <= task_d;
      plate_q       <= plate_d;
      floor_q       <= floor_d;
      leak_prev_q   <= leakage;
      lfloor_prev_q <= leakage_floor;
      leak_pend_q   <= leak_pend_d;
      leak_floor_q  <= leak_floor_d;
      drop_q        <= drop_d;
    end
  end

  assign todo_exists        = task_q != TASK_NONE;
  assign todo_in            = task_q == TASK_IN;
  assign todo_out           = task_q == TASK_OUT;
  assign todo_leak_move     = task_q == TASK_LEAK;
  assign todo_license_plate = plate_q;
  assign todo_floor         = floor_q;
  assign queue_full         = full;
  assign req_dropped        = drop_q;

endmodule

// File: tb/tb_parking_task_scheduler.sv
// Directed bench for parking_task_scheduler; expectations depend on
// whether SCHED_DUP_FILTER_EN is defined.
module tb_parking_task_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] license_plate;
  logic        in_mode, out_mode, leakage, task_done;
  logic [2:0]  leakage_floor;
  logic        todo_exists, todo_in, todo_out, todo_leak_move;
  logic [15:0] todo_license_plate;
  logic [2:0]  todo_floor;
  logic [2:0]  queue_count;
  logic        queue_full, req_dropped;

  int errors = 0;
  int checks = 0;

  parking_task_scheduler #(.DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .license_plate      (license_plate),
    .in_mode            (in_mode),
    .out_mode           (out_mode),
    .leakage            (leakage),
    .leakage_floor      (leakage_floor),
    .task_done          (task_done),
    .todo_exists        (todo_exists),
    .todo_in            (todo_in),
    .todo_out           (todo_out),
    .todo_leak_move     (todo_leak_move),
    .todo_license_plate (todo_license_plate),
    .todo_floor         (todo_floor),
    .queue_count        (queue_count),
    .queue_full         (queue_full),
    .req_dropped        (req_dropped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    in_mode = 0; out_mode = 0; leakage = 0; task_done = 0;
    leakage_floor = 0; license_plate = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  // push one in-request then let it dispatch, leaving the DUT BUSY
  task automatic go_busy(input logic [15:0] p);
    license_plate = p; in_mode = 1;
    tick();
    in_mode = 0;
    tick();
  endtask

  task automatic done_pulse();
    task_done = 1;
    tick();
    task_done = 0;
  endtask

  initial begin
    // T1: reset dominates an active in_mode
    in_mode = 1; out_mode = 0; leakage = 0; task_done = 0;
    leakage_floor = 0; license_plate = 16'h1234; reset = 1;
    tick(); tick();
    reset = 0; in_mode = 0;
    tick();
    chk("t1_exists", 32'(todo_exists), 0);
    chk("t1_count", 32'(queue_count), 0);
    chk("t1_plate", 32'(todo_license_plate), 0);
    chk("t1_drop", 32'(req_dropped), 0);
    chk("t1_flags", 32'({todo_in, todo_out, todo_leak_move}), 0);

    // T2: basic in request, minimum latency
    license_plate = 16'h9423; in_mode = 1;
    tick();
    in_mode = 0;
    chk("t2_cnt_n", 32'(queue_count), 1);
    chk("t2_exist_n", 32'(todo_exists), 0);
    tick();
    chk("t2_exists", 32'(todo_exists), 1);
    chk("t2_in", 32'(todo_in), 1);
    chk("t2_plate", 32'(todo_license_plate), 32'h9423);
    chk("t2_cnt", 32'(queue_count), 0);
    tick(); tick();
    chk("t2_hold", 32'(todo_license_plate), 32'h9423);
    done_pulse();
    chk("t2_done_ex", 32'(todo_exists), 0);
    chk("t2_done_pl", 32'(todo_license_plate), 0);
    task_done = 1;
    tick();
    task_done = 0;
    chk("t2_idle_done", 32'(todo_exists), 0);

    // T3: leak beats the queued request
    do_reset();
    go_busy(16'h1111);
    license_plate = 16'h8754; in_mode = 1;
    tick();
    in_mode = 0;
    chk("t3_cnt", 32'(queue_count), 1);
    leakage = 1; leakage_floor = 3;
    tick();
    chk("t3_nopreempt", 32'(todo_license_plate), 32'h1111);
    done_pulse();
    chk("t3_gap", 32'(todo_exists), 0);
    tick();
    chk("t3_leak", 32'(todo_leak_move), 1);
    chk("t3_floor", 32'(todo_floor), 3);
    chk("t3_lplate", 32'(todo_license_plate), 0);
    chk("t3_lcnt", 32'(queue_count), 1);
    done_pulse();
    tick();
    chk("t3_in", 32'(todo_in), 1);
    chk("t3_inplate", 32'(todo_license_plate), 32'h8754);
    chk("t3_infloor", 32'(todo_floor), 0);
    leakage = 0; leakage_floor = 0;

    // T4: overflow and push-with-pop when full
    do_reset();
    go_busy(16'h1111);
    in_mode = 1;
    for (int i = 1; i <= 4; i++) begin
      license_plate = 16'h1000 + 16'(i);
      tick();
    end
    chk("t4_full", 32'(queue_full), 1);
    chk("t4_cnt4", 32'(queue_count), 4);
    chk("t4_nodrop", 32'(req_dropped), 0);
    license_plate = 16'h1005;
    tick();
    in_mode = 0;
    chk("t4_drop", 32'(req_dropped), 1);
    chk("t4_cnt_ovf", 32'(queue_count), 4);
    tick();
    chk("t4_pulse", 32'(req_dropped), 0);
    done_pulse();
    license_plate = 16'h1006; in_mode = 1;
    tick();
    in_mode = 0;
    chk("t4_pp_drop", 32'(req_dropped), 0);
    chk("t4_pp_cnt", 32'(queue_count), 4);
    chk("t4_pp_head", 32'(todo_license_plate), 32'h1001);

    // T5: both modes, zero plate, vanishing leak, out request
    do_reset();
    license_plate = 16'h4321; in_mode = 1; out_mode = 1;
    tick();
    in_mode = 0; out_mode = 0;
    chk("t5_both_drop", 32'(req_dropped), 1);
    chk("t5_both_cnt", 32'(queue_count), 0);
    license_plate = 16'h0000; in_mode = 1;
    tick();
    in_mode = 0;
    chk("t5_zero_drop", 32'(req_dropped), 1);
    chk("t5_zero_cnt", 32'(queue_count), 0);
    go_busy(16'h1111);
    leakage = 1; leakage_floor = 5;
    tick();
    leakage = 0;
    tick();
    done_pulse();
    tick();
    chk("t5_noleak", 32'(todo_exists), 0);
    license_plate = 16'h2222; out_mode = 1;
    tick();
    out_mode = 0;
    tick();
    chk("t5_out", 32'({todo_in, todo_out, todo_leak_move}), 32'b010);
    chk("t5_outpl", 32'(todo_license_plate), 32'h2222);

    // T6: duplicate requests
    do_reset();
    go_busy(16'h1111);
    license_plate = 16'h8754; in_mode = 1;
    tick();
    tick();
    in_mode = 0;
`ifdef SCHED_DUP_FILTER_EN
    chk("t6_dup_drop", 32'(req_dropped), 1);
    chk("t6_dup_cnt", 32'(queue_count), 1);
`else
    chk("t6_dup_drop", 32'(req_dropped), 0);
    chk("t6_dup_cnt", 32'(queue_count), 2);
`endif
    license_plate = 16'h1111; in_mode = 1;
    tick();
    in_mode = 0;
`ifdef SCHED_DUP_FILTER_EN
    chk("t6_cur_drop", 32'(req_dropped), 1);
`else
    chk("t6_cur_drop", 32'(req_dropped), 0);
`endif
    license_plate = 16'h8754; out_mode = 1;
    tick();
    out_mode = 0;
    chk("t6_type_ok", 32'(req_dropped), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
